// File: rtl/pipe_pkg.sv
// Shared pipeline types and sizes for the register-file write path.
// Used by the write arbiter and its round-robin grant helper.
package pipe_pkg;
  localparam int REG_N      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NREG       = 8;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_CLEAR
  } arb_state_t;

  typedef enum logic [0:0] {
    WR_A,
    WR_B
  } wr_src_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its own pointer register.
// Pointer always moves to the writer that was not granted.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  import pipe_pkg::*;

  wr_src_t rr_ptr;

  assign gnt_a = en & req_a & (~req_b | (rr_ptr == WR_A));
  assign gnt_b = en & req_b & (~req_a | (rr_ptr == WR_B));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= WR_A;
    end else begin
      unique case (1'b1)
        gnt_a:   rr_ptr <= WR_B;
        gnt_b:   rr_ptr <= WR_A;
        default: rr_ptr <= rr_ptr;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback and load
// return, and sequences a one-register-per-cycle clear-all sweep.
module regfile_wr_arbiter #(
  parameter int N      = pipe_pkg::REG_N,
  parameter int ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int NREG   = pipe_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [N-1:0]      a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [N-1:0]      b_data,
  output logic              b_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data
);
  import pipe_pkg::*;

  if (NREG != (1 << ADDR_W)) begin : g_nreg_chk
    $error("NREG must equal 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic              arb_en;

  // clr_req pre-empts both writers in the cycle it is seen
  assign arb_en = (state == ARB_IDLE) & ~clr_req;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (a_ready),
    .gnt_b (b_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          unique case (1'b1)
            clr_req: begin
              state    <= ARB_CLEAR;
              cnt      <= '0;
              clr_busy <= 1'b1;
              wr_en    <= 1'b0;
            end
            a_ready: begin
              wr_en   <= 1'b1;
              wr_addr <= a_addr;
              wr_data <= a_data;
            end
            b_ready: begin
              wr_en   <= 1'b1;
              wr_addr <= b_addr;
              wr_data <= b_data;
            end
            default: wr_en <= 1'b0;
          endcase
        end
        ARB_CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_data <= '0;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= ARB_IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule
